can_idle_monitor: RTL and testbench

//  Parametrised CAN bus-idle / interframe monitor for the channel unit. Consumes the bit-timing

---
 rtl/can_idle_monitor.sv | 132 +++++++++++++
 tb/tb_can_idle_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/can_idle_monitor.sv
// CAN bus-idle / interframe monitor: resolves sampled bits (1- or 3-sample majority),
// tracks consecutive recessive bits and counts bus-off recovery sequences.
module can_idle_monitor #(
    parameter int IDLE_BITS     = 11,
    parameter int RECOVERY_SEQS = 128,
    parameter int RUN_W         = $clog2(IDLE_BITS + 1),
    parameter int SEQ_W         = $clog2(RECOVERY_SEQS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dIn,
    input  logic             samplePulse,
    input  logic             rateSelector,
    input  logic             busOffMode,
    output logic             bitValid,
    output logic             bitVal,
    output logic [RUN_W-1:0] runCount,
    output logic [SEQ_W-1:0] recoveryCount,
    output logic             interframePeriod,
    output logic             busOffRecovered
);

    typedef enum logic [1:0] {SMP0, SMP1, SMP2} smp_e;

    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(IDLE_BITS);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(IDLE_BITS - 1);
    localparam logic [SEQ_W-1:0] SEQ_FULL = SEQ_W'(RECOVERY_SEQS);

    smp_e             state_q, state_d;
    logic             s0_q, s0_d, s1_q, s1_d;
    logic             valid_q, valid_d, val_q, val_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [SEQ_W-1:0] rec_q, rec_d;
    logic             ifp_q, ifp_d, rcv_q, rcv_d, bus_off_q;
    logic             bo_fall, bo_rise;

    assign bo_fall = bus_off_q && !busOffMode;
    assign bo_rise = !bus_off_q && busOffMode;

    // The 3-sample path is implied by leaving SMP0, so the latched rate lives in the state itself.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        valid_d = 1'b0;
        val_d   = val_q;
        if (samplePulse) begin
            case (state_q)
                SMP0: begin
                    s0_d = dIn;
                    if (rateSelector) begin
                        state_d = SMP1;
                    end else begin
                        valid_d = 1'b1;
                        val_d   = dIn;
                    end
                end
                SMP1: begin
                    s1_d    = dIn;
                    state_d = SMP2;
                end
                SMP2: begin
                    valid_d = 1'b1;
                    val_d   = (s0_q & s1_q) | (s0_q & dIn) | (s1_q & dIn);
                    state_d = SMP0;
                end
                default: state_d = SMP0;
            endcase
        end
    end

    // Bus-off mode edges take priority over the bit being consumed in the same cycle.
    always_comb begin
        run_d = run_q;
        rec_d = rec_q;
        if (bo_fall) begin
            run_d = '0;
            rec_d = '0;
        end else if (bo_rise) begin
            run_d = '0;
        end else if (valid_q) begin
            if (!val_q) begin
                run_d = '0;
            end else if (!busOffMode) begin
                if (run_q != RUN_FULL) run_d = run_q + RUN_W'(1);
            end else if (run_q == RUN_LAST) begin
                run_d = '0;
                if (rec_q != SEQ_FULL) rec_d = rec_q + SEQ_W'(1);
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
        rcv_d = bo_fall ? 1'b0 : (rcv_q | (rec_d == SEQ_FULL));
        ifp_d = (run_d == RUN_FULL) && !busOffMode;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SMP0;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            valid_q   <= 1'b0;
            val_q     <= 1'b0;
            run_q     <= '0;
            rec_q     <= '0;
            ifp_q     <= 1'b0;
            rcv_q     <= 1'b0;
            bus_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            valid_q   <= valid_d;
            val_q     <= val_d;
            run_q     <= run_d;
            rec_q     <= rec_d;
            ifp_q     <= ifp_d;
            rcv_q     <= rcv_d;
            bus_off_q <= busOffMode;
        end
    end

    assign bitValid         = valid_q;
    assign bitVal           = val_q;
    assign runCount         = run_q;
    assign recoveryCount    = rec_q;
    assign interframePeriod = ifp_q;
    assign busOffRecovered  = rcv_q;

endmodule

// File: tb/tb_can_idle_monitor.sv
// Self-checking bench for can_idle_monitor: directed scenarios plus random traffic,
// compared every cycle against a sample-list / run-length reference model.
module tb_can_idle_monitor;

    localparam int IDLE  = 11;
    localparam int SEQS  = 4;
    localparam int RUN_W = $clog2(IDLE + 1);
    localparam int SEQ_W = $clog2(SEQS + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             dIn = 1'b1, samplePulse = 1'b0, rateSelector = 1'b0, busOffMode = 1'b0;
    logic             bitValid, bitVal, interframePeriod, busOffRecovered;
    logic [RUN_W-1:0] runCount;
    logic [SEQ_W-1:0] recoveryCount;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    can_idle_monitor #(.IDLE_BITS(IDLE), .RECOVERY_SEQS(SEQS)) dut (
        .clk(clk), .reset(reset), .dIn(dIn), .samplePulse(samplePulse),
        .rateSelector(rateSelector), .busOffMode(busOffMode),
        .bitValid(bitValid), .bitVal(bitVal), .runCount(runCount),
        .recoveryCount(recoveryCount), .interframePeriod(interframePeriod),
        .busOffRecovered(busOffRecovered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a bit is the list of samples gathered since the last bit ended;
    // its length target (1 or 3) is fixed by the rate seen at the first sample.
    int m_smp[$];
    int m_need = 1;
    int m_run = 0, m_rec = 0;
    bit m_valid = 0, m_val = 0, m_ifp = 0, m_ok = 0, m_prev_bo = 0;

    task automatic m_clear();
        m_smp.delete();
        m_need = 1; m_run = 0; m_rec = 0;
        m_valid = 0; m_val = 0; m_ifp = 0; m_ok = 0; m_prev_bo = 0;
    endtask

    task automatic m_step();
        bit old_valid = m_valid;
        bit old_val   = m_val;
        int sum;
        m_valid = 0;
        if (samplePulse) begin
            if (m_smp.size() == 0) m_need = rateSelector ? 3 : 1;
            m_smp.push_back(int'(dIn));
            if (m_smp.size() == m_need) begin
                sum = 0;
                foreach (m_smp[i]) sum += m_smp[i];
                m_val   = (m_need == 1) ? (sum == 1) : (sum >= 2);
                m_valid = 1;
                m_smp.delete();
            end
        end
        if (m_prev_bo && !busOffMode) begin
            m_run = 0; m_rec = 0; m_ok = 0;
        end else if (!m_prev_bo && busOffMode) begin
            m_run = 0;
        end else if (old_valid) begin
            if (!old_val) m_run = 0;
            else if (!busOffMode) m_run = (m_run + 1 > IDLE) ? IDLE : m_run + 1;
            else if (m_run + 1 == IDLE) begin
                m_run = 0;
                m_rec = (m_rec + 1 > SEQS) ? SEQS : m_rec + 1;
            end else m_run = m_run + 1;
        end
        if (m_rec == SEQS && busOffMode) m_ok = 1;
        m_ifp = (m_run == IDLE) && !busOffMode;
        m_prev_bo = busOffMode;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_clear();
        else m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bitValid", bitValid, m_valid);
            check("bitVal", bitVal, m_val);
            check("runCount", runCount, m_run);
            check("recoveryCount", recoveryCount, m_rec);
            check("interframe", interframePeriod, m_ifp);
            check("recovered", busOffRecovered, m_ok);
        end
    end

    task automatic cyc(input bit p, input bit d, input bit r, input bit bo);
        @(posedge clk);
        #2;
        samplePulse  = p;
        dIn          = d;
        rateSelector = r;
        busOffMode   = bo;
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_valid", bitValid, 0);
        check("rst_run", runCount, 0);
        check("rst_rec", recoveryCount, 0);
        check("rst_ifp", interframePeriod, 0);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    bit r_rate, r_bo;

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        check("reset_run", runCount, 0);
        check("reset_valid", bitValid, 0);

        // Eleven recessive single-sample bits reach idle; one dominant bit ends it.
        repeat (IDLE) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t1_ifp_set", interframePeriod, 1);
        check("t1_run_full", runCount, IDLE);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t1_ifp_clr", interframePeriod, 0);
        check("t1_run_clr", runCount, 0);

        // Three-sample majority.
        cyc(1, 1, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        check("t2_bit_101", bitVal, 1);
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        check("t2_bit_001", bitVal, 0);
        cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 0, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        check("t2_bit_110", bitVal, 1);

        // Rate drops mid-bit: current bit still takes three samples, next takes one.
        cyc(1, 1, 1, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t3_bit_110", bitVal, 1);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t3_single", bitVal, 0);

        // Bus-off recovery: four runs of eleven recessive bits.
        cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
        for (int k = 0; k < SEQS; k++) begin
            repeat (IDLE) cyc(1, 1, 0, 1);
            cyc(1, 0, 0, 1);
        end
        cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
        check("t4_rec_full", recoveryCount, SEQS);
        check("t4_recovered", busOffRecovered, 1);
        check("t4_ifp_low", interframePeriod, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t4_rec_clr", recoveryCount, 0);
        check("t4_rcv_clr", busOffRecovered, 0);

        // Reset between second and third sample, then with a partial run.
        cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(0, 1, 1, 0);
        async_reset();
        cyc(1, 0, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        check("t5_no_early_bit", bitValid, 0);
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t5_fresh_bit", bitVal, 0);
        repeat (7) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        check("t5_run7", runCount, 7);
        async_reset();

        // Back-to-back pulses with alternating level.
        repeat (4) begin
            cyc(1, 1, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(0, 1, 0, 0);

        // Random traffic.
        r_rate = 0; r_bo = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) r_rate = ~r_rate;
            if ($urandom_range(0, 299) == 0) r_bo = ~r_bo;
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 29) != 0), r_rate, r_bo);
            if ($urandom_range(0, 999) == 0) async_reset();
        end
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
